st_triple_initiator: RTL and testbench
======================================

// Module: st_triple_initiator
// PURPOSE
//  Initiator side of the three-operand Avalon-ST compute interface: three 8-bit operand sinks plus a 16-bit result source.
//  Accepts a packed 24-bit operand command and fans it out to three independent 8-bit ST sources (A, B, C).
//  Collects the 16-bit result from the compute block's result source and delivers it downstream, flagged with error.
//  Sits between a command producer (CPU/DMA bridge) and the compute block, one transaction in flight.
// PARAMETERS
//  TIMEOUT  256  max cycles in WAIT before an error result is forced; 0 disables the timeout
//  CNT_W    16   width of coe_txn_count
// PORTS
//  Clocking: one clock; reset is synchronous and active-high (csi_clk, rsi_reset).
//  csi_clk         in   1      clock
//  rsi_reset       in   1      synchronous reset, active-high
//  asi_cmd_data    in   24     {A[23:16], B[15:8], C[7:0]}
//  asi_cmd_valid   in   1      command valid
//  asi_cmd_ready   out  1      command ready (IDLE only)
//  aso_a_data      out  8      operand A to compute block
//  aso_a_valid     out  1      operand A valid
//  aso_a_ready     in   1      operand A ready
//  aso_b_data/_valid/_ready    same as A, operand B
//  aso_c_data/_valid/_ready    same as A, operand C
//  asi_res_data    in   16     result from compute block
//  asi_res_valid   in   1      result valid
//  asi_res_ready   out  1      result ready (WAIT only)
//  aso_out_data    out  16     delivered result
//  aso_out_valid   out  1      delivered result valid
//  aso_out_ready   in   1      downstream ready
//  aso_out_error   out  1      1 = timeout, data forced to 0
//  coe_txn_count   out  CNT_W  count of successful (error=0) deliveries, wraps mod 2^CNT_W
// BEHAVIOUR
//  - Reset:
//    - State: IDLE, with sent[2:0], timer, operand/result regs and coe_txn_count all cleared.
//    - Outputs: all valids, aso_out_error and all data outputs are 0.
//    - Ready outputs: asi_cmd_ready = (state==IDLE) & ~rsi_reset, so it is 0 during reset.
//  - Reset mid-operation: aborts at the next edge; valids drop, the in-flight result is discarded, no count change.
//  - Transfer rule: a transfer occurs on a rising edge with valid & ready both 1.
//  - Stability: data and error are held stable while valid=1 and ready=0.
//  - FSM: IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE.
//  - IDLE: cmd_ready=1. On a cmd transfer, latch A/B/C, clear sent, and go to ISSUE.
//  - ISSUE:
//    - Lane valids: aso_x_valid = ~sent[x]; lanes complete independently, in any order or cycle.
//    - sent[x] sets on a lane x transfer.
//    - Exit: go to WAIT on the edge where all three sent bits are set, counting same-cycle transfers.
//    - No timeout applies in ISSUE; a lane may stall indefinitely.
//  - WAIT:
//    - res_ready=1 and timer counts up each cycle.
//    - Result transfer: latch res_data with error=0, go to DELIVER.
//    - Timeout: when TIMEOUT!=0 and timer reaches TIMEOUT-1 with no transfer, latch data=0 with error=1 and go to DELIVER.
//    - A transfer in that same last cycle wins over the timeout.
//  - DELIVER:
//    - out_valid=1.
//    - On an out transfer, go to IDLE; coe_txn_count++ if error=0.
//    - Stall is unbounded.
//  - res_valid outside WAIT is ignored (res_ready=0). cmd_valid outside IDLE is ignored.
//  - Latency and throughput:
//    - Cmd accepted at edge N drives lane valids from N+1.
//    - With all readies high, sent is set at N+1 and WAIT is entered.
//    - A result at N+2 gives out_valid at N+3.
//    - Maximum throughput is one transaction per 4 cycles.
// TESTING
//  - Reset: assert rsi_reset 2 cycles mid-ISSUE -> all valids 0, cmd_ready 0 during reset and 1 the cycle after, count 0.
//  - Happy path: cmd=24'h03_05_07, all readies 1, result 16'd22 on first WAIT cycle -> out_data=22, error=0, out_valid 3 cycles after cmd, count=1.
//  - Skewed lanes: A ready at +1, C at +4, B at +6 -> each lane valid drops exactly after its own transfer, data held, WAIT entered once, no duplicates.
//  - Timeout: TIMEOUT=8, res_valid never -> out_valid 8 cycles after WAIT entry with data=0 and error=1; count unchanged.
//  - Timeout tie: res_valid in cycle 8 of WAIT -> result accepted, error=0.
//  - Back-pressure: out_ready low 10 cycles -> out data/error stable, cmd_ready 0, res_valid pulses ignored; release -> IDLE, count++.
//  - Wrap: CNT_W=2, 5 successful transactions -> coe_txn_count reads 1.

Source files
------------

// File: rtl/st_triple_initiator_if.sv
// Streaming bundle between the command producer, the compute block
// and the downstream result consumer.
interface st_triple_initiator_if #(
    parameter int CNT_W = 16
);
    logic [23:0]      asi_cmd_data;
    logic             asi_cmd_valid;
    logic             asi_cmd_ready;
    logic [7:0]       aso_a_data;
    logic             aso_a_valid;
    logic             aso_a_ready;
    logic [7:0]       aso_b_data;
    logic             aso_b_valid;
    logic             aso_b_ready;
    logic [7:0]       aso_c_data;
    logic             aso_c_valid;
    logic             aso_c_ready;
    logic [15:0]      asi_res_data;
    logic             asi_res_valid;
    logic             asi_res_ready;
    logic [15:0]      aso_out_data;
    logic             aso_out_valid;
    logic             aso_out_ready;
    logic             aso_out_error;
    logic [CNT_W-1:0] coe_txn_count;

    modport master (
        input  asi_cmd_data, asi_cmd_valid,
        output asi_cmd_ready,
        output aso_a_data, aso_a_valid,
        input  aso_a_ready,
        output aso_b_data, aso_b_valid,
        input  aso_b_ready,
        output aso_c_data, aso_c_valid,
        input  aso_c_ready,
        input  asi_res_data, asi_res_valid,
        output asi_res_ready,
        output aso_out_data, aso_out_valid, aso_out_error,
        input  aso_out_ready,
        output coe_txn_count
    );

    modport slave (
        output asi_cmd_data, asi_cmd_valid,
        input  asi_cmd_ready,
        input  aso_a_data, aso_a_valid,
        output aso_a_ready,
        input  aso_b_data, aso_b_valid,
        output aso_b_ready,
        input  aso_c_data, aso_c_valid,
        output aso_c_ready,
        output asi_res_data, asi_res_valid,
        input  asi_res_ready,
        input  aso_out_data, aso_out_valid, aso_out_error,
        output aso_out_ready,
        input  coe_txn_count
    );
endinterface

// File: rtl/st_triple_initiator.sv
// Splits a packed 3-operand command into three ST lanes, waits for the
// compute result (with optional timeout) and delivers it downstream.
module st_triple_initiator #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input logic                   csi_clk,
    input logic                   rsi_reset,
    st_triple_initiator_if.master bus
);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t           state_q;
    logic [7:0]       a_q, b_q, c_q;
    logic [2:0]       vld_q, sent_q;
    logic [TW-1:0]    timer_q;
    logic             idle_q, res_rdy_q;
    logic             out_vld_q, out_err_q;
    logic [15:0]      out_data_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0] xfer;
    logic [2:0] sent_d;
    logic       cmd_rdy;
    logic       tmo_hit;

    // Lane bit order: [2]=A, [1]=B, [0]=C, matching the command packing.
    assign xfer = vld_q & {bus.aso_a_ready, bus.aso_b_ready, bus.aso_c_ready};
    assign sent_d  = sent_q | xfer;
    assign cmd_rdy = idle_q & ~rsi_reset;
    assign tmo_hit = (TIMEOUT != 0) && (timer_q == TW'(TLAST));

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            vld_q      <= '0;
            sent_q     <= '0;
            timer_q    <= '0;
            idle_q     <= 1'b1;
            res_rdy_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_err_q  <= 1'b0;
            out_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.asi_cmd_valid) begin
                        {a_q, b_q, c_q} <= bus.asi_cmd_data;
                        sent_q  <= '0;
                        vld_q   <= 3'b111;
                        idle_q  <= 1'b0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    sent_q <= sent_d;
                    vld_q  <= vld_q & ~xfer;
                    if (sent_d == 3'b111) begin
                        timer_q   <= '0;
                        res_rdy_q <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.asi_res_valid || tmo_hit) begin
                        // A result in the final cycle beats the timeout.
                        out_data_q <= bus.asi_res_valid ? bus.asi_res_data : '0;
                        out_err_q  <= ~bus.asi_res_valid;
                        out_vld_q  <= 1'b1;
                        res_rdy_q  <= 1'b0;
                        state_q    <= DELIVER;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                DELIVER: begin
                    if (bus.aso_out_ready) begin
                        if (!out_err_q) cnt_q <= cnt_q + 1'b1;
                        out_vld_q <= 1'b0;
                        idle_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.asi_cmd_ready = cmd_rdy;
    assign bus.aso_a_data    = a_q;
    assign bus.aso_b_data    = b_q;
    assign bus.aso_c_data    = c_q;
    assign bus.aso_a_valid   = vld_q[2];
    assign bus.aso_b_valid   = vld_q[1];
    assign bus.aso_c_valid   = vld_q[0];
    assign bus.asi_res_ready = res_rdy_q;
    assign bus.aso_out_data  = out_data_q;
    assign bus.aso_out_valid = out_vld_q;
    assign bus.aso_out_error = out_err_q;
    assign bus.coe_txn_count = cnt_q;
endmodule

// File: tb/tb_st_triple_initiator.sv
// Directed bench for st_triple_initiator: vector table plus
// hand-written reset, skew, timeout-tie, back-pressure and wrap cases.
module tb_st_triple_initiator;
    localparam int TO = 8;
    localparam int CW = 2;

    typedef struct {
        logic [23:0] cmd;
        logic        use_res;
        logic [15:0] res;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    st_triple_initiator_if #(.CNT_W(CW)) bus ();

    st_triple_initiator #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .csi_clk  (clk),
        .rsi_reset(rst),
        .bus      (bus)
    );

    int total = 0;
    int bad = 0;
    logic [CW-1:0] cnt_exp = '0;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readies(input logic a, input logic b, input logic c);
        bus.aso_a_ready = a;
        bus.aso_b_ready = b;
        bus.aso_c_ready = c;
    endtask

    task automatic send_cmd(input logic [23:0] cmd);
        bus.asi_cmd_valid = 1'b1;
        bus.asi_cmd_data  = cmd;
        tick();
        bus.asi_cmd_valid = 1'b0;
        chk("lane_vld_start",
            {bus.aso_a_valid, bus.aso_b_valid, bus.aso_c_valid}, 3'b111);
        chk("lane_data", {bus.aso_a_data, bus.aso_b_data, bus.aso_c_data},
            cmd);
    endtask

    task automatic release_out(input logic err);
        bus.aso_out_ready = 1'b1;
        tick();
        bus.aso_out_ready = 1'b0;
        if (!err) cnt_exp = cnt_exp + 1'b1;
        chk("out_vld_drop", bus.aso_out_valid, 1'b0);
        chk("count", bus.coe_txn_count, cnt_exp);
    endtask

    task automatic txn(input vec_t v);
        readies(1'b1, 1'b1, 1'b1);
        send_cmd(v.cmd);
        tick();
        chk("wait_res_rdy", bus.asi_res_ready, 1'b1);
        chk("lane_vld_done",
            {bus.aso_a_valid, bus.aso_b_valid, bus.aso_c_valid}, 3'b000);
        if (v.use_res) begin
            bus.asi_res_valid = 1'b1;
            bus.asi_res_data  = v.res;
            tick();
            bus.asi_res_valid = 1'b0;
        end else begin
            repeat (TO - 1) tick();
            chk("pre_timeout_vld", bus.aso_out_valid, 1'b0);
            tick();
        end
        chk("out_vld", bus.aso_out_valid, 1'b1);
        chk("out_data", bus.aso_out_data, v.exp_data);
        chk("out_err", bus.aso_out_error, v.exp_err);
        release_out(v.exp_err);
    endtask

    initial begin
        vecs[0] = '{24'h030507, 1'b1, 16'd22,    16'd22,    1'b0};
        vecs[1] = '{24'hff0102, 1'b1, 16'habcd,  16'habcd,  1'b0};
        vecs[2] = '{24'h123456, 1'b0, 16'hffff,  16'h0000,  1'b1};
        vecs[3] = '{24'h000000, 1'b1, 16'h0000,  16'h0000,  1'b0};

        bus.asi_cmd_valid = 0; bus.asi_cmd_data = '0;
        bus.asi_res_valid = 0; bus.asi_res_data = '0;
        bus.aso_out_ready = 0;
        readies(1'b0, 1'b0, 1'b0);

        // reset state
        tick(); tick();
        chk("rst_cmd_rdy", bus.asi_cmd_ready, 1'b0);
        chk("rst_vlds", {bus.aso_a_valid, bus.aso_b_valid, bus.aso_c_valid,
            bus.asi_res_ready, bus.aso_out_valid}, 5'b0);
        chk("rst_out", {bus.aso_out_error, bus.aso_out_data}, 17'h0);
        chk("rst_count", bus.coe_txn_count, 2'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_rdy", bus.asi_cmd_ready, 1'b1);

        // reset mid-ISSUE
        send_cmd(24'h0a0b0c);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_rdy", bus.asi_cmd_ready, 1'b0);
        tick(); tick();
        chk("mid_rst_vlds",
            {bus.aso_a_valid, bus.aso_b_valid, bus.aso_c_valid}, 3'b000);
        chk("mid_rst_cmd_rdy2", bus.asi_cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_release", bus.asi_cmd_ready, 1'b1);
        chk("mid_rst_count", bus.coe_txn_count, 2'd0);
        tick();
        chk("mid_rst_idle", bus.asi_cmd_ready, 1'b1);

        // table vectors
        for (int i = 0; i < 4; i++) txn(vecs[i]);

        // skewed lanes: A at +1, C at +4, B at +6
        readies(1'b0, 1'b0, 1'b0);
        send_cmd(24'haabbcc);
        for (int k = 1; k <= 6; k++) begin
            readies(k == 1, k == 6, k == 4);
            tick();
            chk("skew_a_vld", bus.aso_a_valid, 1'b0);
            chk("skew_b_vld", bus.aso_b_valid, k < 6);
            chk("skew_c_vld", bus.aso_c_valid, k < 4);
            chk("skew_res_rdy", bus.asi_res_ready, k == 6);
            chk("skew_data",
                {bus.aso_a_data, bus.aso_b_data, bus.aso_c_data}, 24'haabbcc);
        end
        readies(1'b0, 1'b0, 1'b0);
        bus.asi_res_valid = 1'b1; bus.asi_res_data = 16'h0777;
        tick();
        bus.asi_res_valid = 1'b0;
        chk("skew_out", {bus.aso_out_valid, bus.aso_out_data}, 17'h10777);
        release_out(1'b0);

        // result in last WAIT cycle beats timeout
        readies(1'b1, 1'b1, 1'b1);
        send_cmd(24'h010203);
        tick();
        repeat (TO - 1) tick();
        chk("tie_not_yet", bus.aso_out_valid, 1'b0);
        bus.asi_res_valid = 1'b1; bus.asi_res_data = 16'h55aa;
        tick();
        bus.asi_res_valid = 1'b0;
        chk("tie_out", {bus.aso_out_valid, bus.aso_out_error,
            bus.aso_out_data}, {2'b10, 16'h55aa});
        release_out(1'b0);

        // back-pressure on the output
        send_cmd(24'h111111);
        tick();
        bus.asi_res_valid = 1'b1; bus.asi_res_data = 16'h1234;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.asi_res_valid = i[0];
            bus.asi_res_data  = 16'hffff;
            bus.asi_cmd_valid = 1'b1;
            bus.asi_cmd_data  = 24'h999999;
            tick();
            chk("bp_out", {bus.aso_out_valid, bus.aso_out_error,
                bus.aso_out_data}, {2'b10, 16'h1234});
            chk("bp_cmd_rdy", bus.asi_cmd_ready, 1'b0);
        end
        bus.asi_res_valid = 1'b0;
        bus.asi_cmd_valid = 1'b0;
        release_out(1'b0);
        chk("bp_idle", bus.asi_cmd_ready, 1'b1);

        // counter wrap: 5 successes from reset on a 2-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_exp = '0;
        for (int i = 0; i < 5; i++) txn(vecs[1]);
        chk("wrap_count", bus.coe_txn_count, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
